// File: rtl/pc_fetch_unit.sv
// IF-stage program counter owner: one outstanding instruction fetch, IF/ID handoff, redirect handling.
// Optional performance counters are compiled in when FETCH_PERF_EN is defined.
module pc_fetch_unit #(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_3000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_addr,
   output logic              imem_req_valid,
   output logic [ADDR_W-1:0] imem_req_addr,
   input  logic              imem_req_ready,
   input  logic              imem_rsp_valid,
   input  logic [ADDR_W-1:0] imem_rsp_data,
   output logic              if_valid,
   input  logic              if_ready,
   output logic [ADDR_W-1:0] if_pc,
   output logic [ADDR_W-1:0] if_ins,
   output logic [ADDR_W-1:0] if_pc_plus4,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_redirects,
   output logic [31:0]       perf_stalls
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t            state;
   logic [ADDR_W-1:0] pc;
   logic [ADDR_W-1:0] ins_q;
   logic              drop;
   logic              active;
   logic [ADDR_W-1:0] redir_pc;
   logic [ADDR_W-1:0] pc_next4;

   assign active   = (state != S_IDLE);
   assign redir_pc = redirect_addr & ~ADDR_W'(3);
   assign pc_next4 = pc + ADDR_W'(4);

   // IDLE only ever follows reset, so gating pc here keeps every output at zero there.
   assign imem_req_valid = (state == S_REQ);
   assign if_valid       = (state == S_HOLD);
   assign imem_req_addr  = active ? pc : '0;
   assign if_pc          = active ? pc : '0;
   assign if_pc_plus4    = active ? pc_next4 : '0;
   assign if_ins         = ins_q;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         pc    <= RESET_PC;
         drop  <= 1'b0;
         ins_q <= '0;
      end else begin
         unique case (state)
            S_IDLE: state <= S_REQ;
            S_REQ: begin
               if (redirect_valid) pc <= redir_pc;
               if (imem_req_ready) begin
                  state <= S_WAIT;
                  // An accepted request for the old address must be thrown away.
                  drop  <= redirect_valid;
               end
            end
            S_WAIT: begin
               if (redirect_valid) begin
                  pc <= redir_pc;
                  if (imem_rsp_valid) begin
                     drop  <= 1'b0;
                     state <= S_REQ;
                  end else begin
                     drop <= 1'b1;
                  end
               end else if (imem_rsp_valid) begin
                  if (drop) begin
                     drop  <= 1'b0;
                     state <= S_REQ;
                  end else begin
                     ins_q <= imem_rsp_data;
                     state <= S_HOLD;
                  end
               end
            end
            S_HOLD: begin
               if (redirect_valid) begin
                  pc    <= redir_pc;
                  state <= S_REQ;
               end else if (if_ready) begin
                  pc    <= pc_next4;
                  state <= S_REQ;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

`ifdef FETCH_PERF_EN
   logic redirect_taken;
   assign redirect_taken = redirect_valid && active;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_fetched   <= '0;
         perf_redirects <= '0;
         perf_stalls    <= '0;
      end else begin
         if (if_valid && if_ready && !redirect_valid) perf_fetched <= perf_fetched + 32'd1;
         if (redirect_taken) perf_redirects <= perf_redirects + 32'd1;
         if (if_valid && !if_ready) perf_stalls <= perf_stalls + 32'd1;
      end
   end
`else
   assign perf_fetched   = '0;
   assign perf_redirects = '0;
   assign perf_stalls    = '0;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Randomized bench for pc_fetch_unit: a memory responder with random latency and a
// program-order model (next expected PC, instruction image, perf counts) checked every cycle.
module tb_pc_fetch_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_3000;
`ifdef FETCH_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_addr;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_pc;
   logic [31:0] if_ins;
   logic [31:0] if_pc_plus4;
   logic [31:0] perf_fetched;
   logic [31:0] perf_redirects;
   logic [31:0] perf_stalls;

   pc_fetch_unit #(.ADDR_W(32), .RESET_PC(RESET_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_addr  (redirect_addr),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .if_valid       (if_valid),
      .if_ready       (if_ready),
      .if_pc          (if_pc),
      .if_ins         (if_ins),
      .if_pc_plus4    (if_pc_plus4),
      .perf_fetched   (perf_fetched),
      .perf_redirects (perf_redirects),
      .perf_stalls    (perf_stalls)
   );

   always #5 clk = ~clk;

   int n_tests  = 0;
   int n_failed = 0;

   // stimulus knobs
   int rdy_pct = 100;
   int ifr_pct = 100;
   int lat_max = 0;

   // reference model: program order plus a one-deep memory
   logic [31:0] exp_pc    = RESET_PC;
   int unsigned m_fetched = 0;
   int unsigned m_redirs  = 0;
   int unsigned m_stalls  = 0;
   bit          prev_rst  = 1'b0;
   bit          mem_out   = 1'b0;
   logic [31:0] mem_addr  = '0;
   int          mem_cnt   = 0;
   int          cycle     = 0;
   bit          period_on = 1'b0;
   int          last_v    = -1;
   int          since_del = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h2002_0001 ^ ((a - 32'h3000) * 32'h9E37_79B9);
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_failed++;
         $display("FAIL %s @cycle %0d: got %h expected %h", tag, cycle, got, exp);
      end
   endtask

   // Observe outputs at the falling edge, between two active edges.
   task automatic sync();
      logic [31:0] exp_p4;
      @(negedge clk);
      cycle++;
      exp_p4 = exp_pc + 32'd4;
      if (!prev_rst) begin
         check("idle_valids", {imem_req_valid, if_valid}, 0);
         check("idle_addr", {imem_req_addr, if_pc}, 0);
         check("idle_data", {if_ins, if_pc_plus4}, 0);
      end else begin
         if (imem_req_valid) check("req_addr", imem_req_addr, exp_pc);
         if (if_valid) begin
            check("if_pc", if_pc, exp_pc);
            check("if_ins", if_ins, mem_word(exp_pc));
            check("if_pc_plus4", if_pc_plus4, exp_p4);
         end
         check("req_and_if_valid", imem_req_valid && if_valid, 0);
      end
      if (period_on && if_valid) begin
         if (last_v >= 0) check("if_valid_period", cycle - last_v, 3);
         last_v = cycle;
      end
      check("perf_fetched", perf_fetched, PERF ? m_fetched : 0);
      check("perf_redirects", perf_redirects, PERF ? m_redirs : 0);
      check("perf_stalls", perf_stalls, PERF ? m_stalls : 0);
   endtask

   // Drive inputs for the coming rising edge and advance the model across it.
   task automatic drive(input logic rv, input logic redir, input logic [31:0] tgt);
      bit active;
      rst_n          = rv;
      redirect_valid = redir;
      redirect_addr  = tgt;
      imem_req_ready = ($urandom_range(99) < rdy_pct);
      if_ready       = ($urandom_range(99) < ifr_pct);
      imem_rsp_valid = mem_out && (mem_cnt == 0);
      imem_rsp_data  = imem_rsp_valid ? mem_word(mem_addr) : $urandom;

      active = rv && prev_rst;
      since_del++;
      if (!rv) begin
         exp_pc    = RESET_PC;
         m_fetched = 0;
         m_redirs  = 0;
         m_stalls  = 0;
         mem_out   = 1'b0;
         since_del = 0;
      end else begin
         if (if_valid && !if_ready) m_stalls++;
         if (active && redir) begin
            exp_pc = tgt & ~32'd3;
            m_redirs++;
         end else if (if_valid && if_ready) begin
            exp_pc = exp_pc + 32'd4;
            m_fetched++;
            since_del = 0;
         end
         if (imem_rsp_valid) mem_out = 1'b0;
         if (imem_req_valid && imem_req_ready) begin
            check("one_outstanding", mem_out, 0);
            mem_out  = 1'b1;
            mem_addr = imem_req_addr;
            mem_cnt  = $urandom_range(lat_max);
         end else if (mem_out && mem_cnt > 0) begin
            mem_cnt--;
         end
      end
      prev_rst = rv;
      if (since_del > 400) begin
         check("progress_watchdog", since_del, 0);
         since_del = 0;
      end
   endtask

   task automatic reset_dut();
      drive(1'b0, 1'b0, '0);
      sync();
      drive(1'b0, 1'b0, '0);
      sync();
   endtask

   // 0: if_valid, 1: imem_req_valid, 2: fetch outstanding in memory
   task automatic wait_for(input int what);
      int  n = 0;
      bit  hit;
      hit = (what == 0) ? if_valid : (what == 1) ? imem_req_valid : mem_out;
      while (!hit && n < 60) begin
         drive(1'b1, 1'b0, '0);
         sync();
         n++;
         hit = (what == 0) ? if_valid : (what == 1) ? imem_req_valid : mem_out;
      end
      check("wait_timeout", n < 60, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish, n_failed %0d", n_failed);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0; if_ready = 1'b0;
      repeat (2) @(posedge clk);
      sync();

      // full-speed streaming: one delivery every third cycle
      period_on = 1'b1;
      repeat (30) begin
         drive(1'b1, 1'b0, '0);
         sync();
      end
      period_on = 1'b0;
      check("stream_count", m_fetched, 9);

      // decode stall in HOLD
      reset_dut();
      wait_for(0);
      ifr_pct = 0;
      repeat (5) begin
         drive(1'b1, 1'b0, '0);
         sync();
      end
      check("stall_pc", if_pc, 32'h3000);
      check("stall_ins", if_ins, 32'h2002_0001);
      check("stall_noreq", imem_req_valid, 0);
      ifr_pct = 100;

      // redirect coinciding with acceptance of the 3008 request
      wait_for(1);
      drive(1'b1, 1'b0, '0);
      sync();
      wait_for(1);
      check("req_3008", imem_req_addr, 32'h3008);
      drive(1'b1, 1'b1, 32'h0000_3040);
      sync();
      wait_for(0);
      check("redir_if_pc", if_pc, 32'h3040);

      // redirect while holding with if_ready high; target low bits ignored
      drive(1'b1, 1'b1, 32'h0000_3102);
      sync();
      wait_for(1);
      check("redir_req_addr", imem_req_addr, 32'h3100);

      // reset while a fetch is outstanding
      wait_for(2);
      drive(1'b0, 1'b0, '0);
      sync();
      wait_for(1);
      check("post_reset_req", imem_req_addr, 32'h3000);

      // address wrap at the top of the space
      drive(1'b1, 1'b1, 32'hFFFF_FFFC);
      sync();
      wait_for(0);
      check("top_if_pc", if_pc, 32'hFFFF_FFFC);
      check("top_plus4", if_pc_plus4, 32'h0);
      drive(1'b1, 1'b0, '0);
      sync();
      wait_for(1);
      check("wrap_req_addr", imem_req_addr, 32'h0);

      // randomized traffic
      for (int seg = 0; seg < 40; seg++) begin
         int redir_pct;
         rdy_pct   = $urandom_range(100, 30);
         ifr_pct   = $urandom_range(100, 30);
         lat_max   = $urandom_range(3);
         redir_pct = $urandom_range(10);
         for (int c = 0; c < 100; c++) begin
            logic        rv;
            logic        rd;
            logic [31:0] tg;
            rv = ($urandom_range(99) != 0);
            rd = ($urandom_range(99) < redir_pct);
            tg = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 + $urandom_range(15)) : $urandom;
            drive(rv, rd, tg);
            sync();
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
      $finish;
   end

endmodule
